// File: rtl/mux_rr_stream_if.sv
// Stream bundle for mux_rr_stream: N parallel producer lanes in, one registered lane out.
interface mux_rr_stream_if #(
  parameter int W     = 4,
  parameter int N     = 16,
  parameter int SEL_W = 4
);
  logic [N*W-1:0] inp_mux;
  logic [N-1:0]   inp_valid;
  logic [N-1:0]   inp_ready;
  logic           mode;
  logic [SEL_W-1:0] select;
  logic [W-1:0]     out_mux;
  logic [SEL_W-1:0] out_sel;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output inp_mux, inp_valid, mode, select, out_ready,
    input  inp_ready, out_mux, out_sel, out_valid
  );

  modport slave (
    input  inp_mux, inp_valid, mode, select, out_ready,
    output inp_ready, out_mux, out_sel, out_valid
  );
endinterface

// File: rtl/mux_rr_stream.sv
// N:1 stream multiplexer with fixed-select or round-robin arbitration feeding
// a single registered output slot with valid/ready handshakes.
module mux_rr_stream #(
  parameter int W     = 4,
  parameter int N     = 16,
  parameter int SEL_W = 4
) (
  input logic            clk,
  input logic            rst_n,
  mux_rr_stream_if.slave bus
);

  localparam logic [N-1:0] one_hot0 = {{(N-1){1'b0}}, 1'b1};

  logic [W-1:0]     data_p0;
  logic [SEL_W-1:0] sel_p0;
  logic             vld_p0;
  logic [SEL_W-1:0] ptr;

  logic             found;
  logic [SEL_W-1:0] cand;
  int               idx;
  logic [N-1:0]     vshift;
  logic [N*W-1:0]   dshift;
  logic [W-1:0]     cand_data;
  logic             load_en;
  logic             xfer;

  // Candidate selection: round-robin starts searching just after the last grant.
  always_comb begin
    found  = 1'b0;
    cand   = '0;
    idx    = 0;
    vshift = '0;
    if (bus.mode) begin
      for (int k = 1; k <= N; k++) begin
        idx    = (int'(ptr) + k) % N;
        vshift = bus.inp_valid >> idx;
        if (!found && vshift[0]) begin
          found = 1'b1;
          cand  = SEL_W'(idx);
        end
      end
    end else if (int'(bus.select) < N) begin
      vshift = bus.inp_valid >> bus.select;
      found  = vshift[0];
      cand   = bus.select;
    end
  end

  assign dshift    = bus.inp_mux >> (int'(cand) * W);
  assign cand_data = dshift[W-1:0];
  assign load_en   = !vld_p0 || bus.out_ready;
  assign xfer      = found && load_en;

  assign bus.inp_ready = (rst_n && xfer) ? (one_hot0 << cand) : '0;

  // Output register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      sel_p0  <= '0;
      ptr     <= SEL_W'(N - 1);
    end else if (xfer) begin
      vld_p0  <= 1'b1;
      data_p0 <= cand_data;
      sel_p0  <= cand;
      ptr     <= cand;
    end else if (bus.out_ready) begin
      vld_p0  <= 1'b0;
    end
  end

  assign bus.out_mux   = data_p0;
  assign bus.out_sel   = sel_p0;
  assign bus.out_valid = vld_p0;

endmodule

// File: tb/tb_mux_rr_stream.sv
// Testbench for mux_rr_stream: directed vector table, hand-written corner sequences,
// then randomized traffic against a behavioural model of the arbitration rules.
module tb_mux_rr_stream;
  localparam int W = 4;
  localparam int N = 16;
  localparam int SEL_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  mux_rr_stream_if #(.W(W), .N(N), .SEL_W(SEL_W)) bus ();

  mux_rr_stream #(.W(W), .N(N), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        mode;
    logic [3:0]  sel;
    logic [15:0] valid;
    logic        ordy;
    logic [15:0] exp_ready;
    logic        exp_vld;
    logic [3:0]  exp_sel;
    logic [3:0]  exp_mux;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(input logic m, input int s, input logic [15:0] v, input logic o,
                              input logic [15:0] er, input logic ev, input int es, input logic [3:0] em);
    vec_t r;
    r.mode = m; r.sel = 4'(s); r.valid = v; r.ordy = o;
    r.exp_ready = er; r.exp_vld = ev; r.exp_sel = 4'(es); r.exp_mux = em;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] s, input logic [3:0] m);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, ".out_sel"}, 32'(bus.out_sel), 32'(s));
    chk({tag, ".out_mux"}, 32'(bus.out_mux), 32'(m));
  endtask

  // Behavioural reference: which channel the arbitration rules pick, or -1.
  function automatic int ref_cand(input bit m, input int s, input logic [15:0] v, input int p);
    if (!m) return (s < N && v[s]) ? s : -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (p + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  int m_vld, m_sel, m_mux, m_ptr;
  logic [3:0] chan_data[N];

  initial begin
    tbl[0]  = mk(0,  5, 16'hFFFF, 1, 16'h0020, 1,  5, 4'hA);
    tbl[1]  = mk(0, 15, 16'h8000, 1, 16'h8000, 1, 15, 4'h0);
    tbl[2]  = mk(1,  0, 16'h8421, 1, 16'h0001, 1,  0, 4'hF);
    tbl[3]  = mk(1,  0, 16'h8421, 1, 16'h0020, 1,  5, 4'hA);
    tbl[4]  = mk(1,  0, 16'h8421, 1, 16'h0400, 1, 10, 4'h5);
    tbl[5]  = mk(1,  0, 16'h8421, 1, 16'h8000, 1, 15, 4'h0);
    tbl[6]  = mk(1,  0, 16'h8421, 1, 16'h0001, 1,  0, 4'hF);
    tbl[7]  = mk(1,  0, 16'h8421, 0, 16'h0000, 1,  0, 4'hF);
    tbl[8]  = mk(1,  0, 16'h8421, 0, 16'h0000, 1,  0, 4'hF);
    tbl[9]  = mk(1,  0, 16'h8421, 0, 16'h0000, 1,  0, 4'hF);
    tbl[10] = mk(1,  0, 16'h8421, 1, 16'h0020, 1,  5, 4'hA);
    tbl[11] = mk(1,  0, 16'h0000, 1, 16'h0000, 0,  5, 4'hA);
    tbl[12] = mk(1,  0, 16'h8000, 1, 16'h8000, 1, 15, 4'h0);
    tbl[13] = mk(1,  0, 16'h0000, 1, 16'h0000, 0, 15, 4'h0);
    tbl[14] = mk(1,  0, 16'h0000, 1, 16'h0000, 0, 15, 4'h0);
    tbl[15] = mk(1,  0, 16'h0000, 1, 16'h0000, 0, 15, 4'h0);
    tbl[16] = mk(1,  0, 16'h0000, 1, 16'h0000, 0, 15, 4'h0);
    tbl[17] = mk(1,  0, 16'h0008, 1, 16'h0008, 1,  3, 4'hC);
    tbl[18] = mk(1,  0, 16'h0009, 1, 16'h0001, 1,  0, 4'hF);
    tbl[19] = mk(1,  0, 16'hFFFF, 1, 16'h0002, 1,  1, 4'hE);
    tbl[20] = mk(0,  2, 16'hFFFF, 1, 16'h0004, 1,  2, 4'hD);
    tbl[21] = mk(1,  0, 16'hFFFF, 1, 16'h0008, 1,  3, 4'hC);
    tbl[22] = mk(0,  7, 16'hFF7F, 1, 16'h0000, 0,  3, 4'hC);

    // Channel i carries ~i during the directed part.
    for (int i = 0; i < N; i++) bus.inp_mux[i*W +: W] = 4'(15 - i);
    bus.inp_valid = 16'hFFFF;
    bus.mode = 1'b1;
    bus.select = 4'd0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;

    // Reset held two cycles with every lane requesting.
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst.inp_ready", 32'(bus.inp_ready), 32'h0);
      chk_out("rst", 1'b0, 4'd0, 4'h0);
    end
    rst_n = 1'b1;
    #1;
    chk("rst.first_grant", 32'(bus.inp_ready), 32'h0001);
    step();
    chk_out("rst.first", 1'b1, 4'd0, 4'hF);

    // Directed vector table.
    for (int t = 0; t < 23; t++) begin
      bus.mode = tbl[t].mode;
      bus.select = tbl[t].sel;
      bus.inp_valid = tbl[t].valid;
      bus.out_ready = tbl[t].ordy;
      #1;
      chk($sformatf("vec%0d.inp_ready", t), 32'(bus.inp_ready), 32'(tbl[t].exp_ready));
      step();
      chk_out($sformatf("vec%0d", t), tbl[t].exp_vld, tbl[t].exp_sel, tbl[t].exp_mux);
    end

    // Reset while the output slot is full.
    bus.mode = 1'b1;
    bus.inp_valid = 16'hFFFF;
    bus.out_ready = 1'b0;
    step();
    chk_out("midrst.load", 1'b1, 4'd4, 4'hB);
    rst_n = 1'b0;
    #1;
    chk("midrst.inp_ready", 32'(bus.inp_ready), 32'h0);
    step();
    chk_out("midrst", 1'b0, 4'd0, 4'h0);

    // Randomized traffic against the reference model.
    m_vld = 0; m_sel = 0; m_mux = 0; m_ptr = N - 1;
    for (int n = 0; n < 800; n++) begin
      int c;
      bit le;
      logic [15:0] er;
      rst_n = ($urandom_range(0, 59) != 0);
      bus.mode = 1'($urandom_range(0, 1));
      bus.select = 4'($urandom_range(0, 15));
      bus.inp_valid = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom & $urandom & $urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        chan_data[i] = 4'($urandom);
        bus.inp_mux[i*W +: W] = chan_data[i];
      end
      #1;
      c = ref_cand(bus.mode, int'(bus.select), bus.inp_valid, m_ptr);
      le = (m_vld == 0) || bus.out_ready;
      er = (rst_n && c >= 0 && le) ? (16'h0001 << c) : 16'h0000;
      chk("rand.inp_ready", 32'(bus.inp_ready), 32'(er));
      if (!rst_n) begin
        m_vld = 0; m_sel = 0; m_mux = 0; m_ptr = N - 1;
      end else if (c >= 0 && le) begin
        m_vld = 1; m_sel = c; m_mux = int'(chan_data[c]); m_ptr = c;
      end else if (bus.out_ready) begin
        m_vld = 0;
      end
      step();
      chk_out("rand", 1'(m_vld), 4'(m_sel), 4'(m_mux));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
